ascon_perm_ctrl: RTL and testbench

Iterative Ascon permutation engine with round sequencing. It accepts a 320-bit state and a round count over a valid/ready handshake. Each clock it applies one round: constant addition, 5-bit S-box layer, then the per-word linear diffusion layer. The AEAD/hash mode FSM uses it to run p^a (12 rounds) and p^b (6 or 8 rounds).

---
 rtl/ascon_perm_ctrl.sv | 145 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: iterative Ascon permutation engine.
// Applies one Ascon round per clock (constant addition, bitsliced 5-bit
// S-box, linear diffusion) to a 320-bit state. It runs the last n rounds
// of the 12-round constant schedule, so p^a (n=12) and p^b (n=6/8) share
// one datapath.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds in_state/in_rounds while in_valid waits.
// The block holds out_valid/out_state stable until out_ready is seen.
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   in_valid     request present (in_state, in_rounds)
//   in_ready     block idle and able to accept
//   in_state     x0=[319:256] x1=[255:192] x2=[191:128] x3=[127:64] x4=[63:0]
//   in_rounds    round count n, 0..12 (13..15 clamp to 12)
//   out_valid    out_state holds the permuted result
//   out_ready    consumer accepts the result
//   out_state    result, same word packing as in_state
//   busy         high while rounds are being applied
//   round_const  constant of the round applied at the next edge, 0 otherwise
module ascon_perm_ctrl #(
  parameter int MAX_ROUNDS = 12,
  parameter int STATE_W    = 320
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [3:0]         in_rounds,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy,
  output logic [7:0]         round_const
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] MAX_R = 4'(MAX_ROUNDS);
  localparam logic [3:0] LAST_R = 4'(MAX_ROUNDS - 1);

  state_e             st_q, st_d;
  logic [STATE_W-1:0] x_q, x_d;
  logic [3:0]         idx_q, idx_d;
  logic [3:0]         n_clamped;
  logic [7:0]         const_cur;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned r);
    return (v >> r) | (v << (64 - r));
  endfunction

  function automatic logic [319:0] perm_round(input logic [319:0] s, input logic [7:0] c);
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;
    x0 = s[319:256];
    x1 = s[255:192];
    x2 = s[191:128] ^ {56'b0, c};
    x3 = s[127:64];
    x4 = s[63:0];
    // S-box layer, bitsliced across all 64 columns
    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;
    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;
    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;
    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;
    // Linear diffusion layer
    x0 = x0 ^ rotr(x0, 19) ^ rotr(x0, 28);
    x1 = x1 ^ rotr(x1, 61) ^ rotr(x1, 39);
    x2 = x2 ^ rotr(x2, 1)  ^ rotr(x2, 6);
    x3 = x3 ^ rotr(x3, 10) ^ rotr(x3, 17);
    x4 = x4 ^ rotr(x4, 7)  ^ rotr(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign n_clamped = (in_rounds > MAX_R) ? MAX_R : in_rounds;
  assign const_cur = {4'hF - idx_q, idx_q};

  // Next-state, datapath and outputs
  always_comb begin
    st_d        = st_q;
    x_d         = x_q;
    idx_d       = idx_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    round_const = 8'h00;
    case (st_q)
      IDLE: begin
        // Gated by rst so in_ready reads 0 while reset is held
        in_ready = ~rst;
        if (in_valid) begin
          x_d   = in_state;
          // Running the last n rounds of the schedule: start part-way in
          idx_d = MAX_R - n_clamped;
          st_d  = (n_clamped == 4'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        round_const = const_cur;
        x_d         = perm_round(x_q, const_cur);
        idx_d       = idx_q + 4'd1;
        if (idx_q == LAST_R) st_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      x_q   <= '0;
      idx_q <= 4'd0;
    end else begin
      st_q  <= st_d;
      x_q   <= x_d;
      idx_q <= idx_d;
    end
  end

  assign out_state = x_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: randomized requests checked against a word-array
// reference of the Ascon permutation, plus directed reset/backpressure cases.
module tb_ascon_perm_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [319:0] in_state;
  logic [3:0]   in_rounds;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] out_state;
  logic         busy;
  logic [7:0]   round_const;

  int checks   = 0;
  int failures = 0;
  logic [319:0] exp_q[$];

  ascon_perm_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_state    (in_state),
    .in_rounds   (in_rounds),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_state   (out_state),
    .busy        (busy),
    .round_const (round_const)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_rotr(input logic [63:0] v, input int r);
    logic [127:0] d;
    d = {v, v} >> r;
    return d[63:0];
  endfunction

  function automatic logic [7:0] ref_const(input int r);
    return 8'(((15 - r) << 4) | r);
  endfunction

  // Runs rounds 12-n .. 11 over a five-word array
  function automatic logic [319:0] ref_perm(input logic [319:0] s, input int n);
    logic [63:0] x[5];
    logic [63:0] t[5];
    int ra[5] = '{19, 61, 1, 10, 7};
    int rb[5] = '{28, 39, 6, 17, 41};
    for (int w = 0; w < 5; w++) x[w] = s[319 - 64*w -: 64];
    for (int r = 12 - n; r < 12; r++) begin
      x[2] = x[2] ^ 64'(ref_const(r));
      x[0] ^= x[4]; x[4] ^= x[3]; x[2] ^= x[1];
      for (int i = 0; i < 5; i++) t[i] = ~x[i] & x[(i+1) % 5];
      for (int i = 0; i < 5; i++) x[i] ^= t[(i+1) % 5];
      x[1] ^= x[0]; x[0] ^= x[4]; x[3] ^= x[2]; x[2] = ~x[2];
      for (int i = 0; i < 5; i++) x[i] = x[i] ^ ref_rotr(x[i], ra[i]) ^ ref_rotr(x[i], rb[i]);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 320'(in_ready), 320'd1);
    check({tag, "_out_valid"}, 320'(out_valid), 320'd0);
    check({tag, "_busy"}, 320'(busy), 320'd0);
  endtask

  // One full transaction: accept, check every RUN cycle, hold DONE for
  // 'hold' cycles with out_ready low (poking in_valid), then release.
  task automatic run_txn(input logic [319:0] s, input logic [3:0] r, input int hold);
    int n;
    logic [319:0] exp;
    n = (r > 12) ? 12 : int'(r);
    exp_q.push_back(ref_perm(s, n));
    @(negedge clk);
    check("pre_in_ready", 320'(in_ready), 320'd1);
    in_valid  = 1'b1;
    in_state  = s;
    in_rounds = r;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_state  = rand_state();
    in_rounds = 4'($urandom_range(0, 15));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check($sformatf("run%0d_busy", i), 320'(busy), 320'd1);
      check($sformatf("run%0d_const", i), 320'(round_const), 320'(ref_const(12 - n + i)));
      check($sformatf("run%0d_out_valid", i), 320'(out_valid), 320'd0);
      check($sformatf("run%0d_in_ready", i), 320'(in_ready), 320'd0);
      // Stray request during RUN must be ignored
      in_valid = (i == 1);
    end
    exp = exp_q.pop_front();
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check("done_out_valid", 320'(out_valid), 320'd1);
      check("done_out_state", out_state, exp);
      check("done_in_ready", 320'(in_ready), 320'd0);
      check("done_busy", 320'(busy), 320'd0);
      check("done_const", 320'(round_const), 320'd0);
      in_valid = (h < hold) && (h == 0);
      out_ready = (h == hold);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_done");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 320'(in_ready), 320'd0);
    check({tag, "_out_valid"}, 320'(out_valid), 320'd0);
    check({tag, "_busy"}, 320'(busy), 320'd0);
    check({tag, "_out_state"}, out_state, 320'd0);
    check({tag, "_const"}, 320'(round_const), 320'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [319:0] pat;
    logic [319:0] s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = '0;
    in_rounds = 4'd0;
    out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // Full p12 on the zero state
    run_txn('0, 4'd12, 0);
    // p^b variants on random states
    run_txn(rand_state(), 4'd6, 0);
    run_txn(rand_state(), 4'd8, 1);
    // Zero rounds: passes the state straight through
    pat = {5{64'h0123456789ABCDEF}};
    run_txn(pat, 4'd0, 0);
    // Clamped count matches 12 rounds
    s = rand_state();
    run_txn(s, 4'd15, 0);
    run_txn(s, 4'd12, 0);
    // Backpressure in DONE
    run_txn(rand_state(), 4'd5, 5);
    // Random mix
    for (int k = 0; k < 12; k++)
      run_txn(rand_state(), 4'($urandom_range(0, 15)), $urandom_range(0, 3));

    // Reset in the middle of a 12-round run
    @(negedge clk);
    in_valid  = 1'b1;
    in_state  = rand_state();
    in_rounds = 4'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("midrun_busy", 320'(busy), 320'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_abort");
    check("after_abort_state", out_state, 320'd0);
    run_txn(rand_state(), 4'd12, 0);

    check("sb_empty", 320'(exp_q.size()), 320'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
